// File: rtl/gate_exhaustive_checker.sv
// Exhaustive stimulus source and response checker for a small combinational gate.
// Walks every input vector in ascending order, holds it, samples the gate and tallies mismatches.
module gate_exhaustive_checker #(
    parameter int unsigned                N_INPUTS      = 2,
    parameter logic [2**N_INPUTS-1:0]     TRUTH_TABLE   = 4'b0111,
    parameter int unsigned                SETTLE_CYCLES = 1,
    parameter int unsigned                ERR_W         = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic                first_err_valid,
    output logic [N_INPUTS-1:0] first_err_vec
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [N_INPUTS-1:0] VEC_ONE  = N_INPUTS'(1);
    localparam logic [ERR_W-1:0]    ERR_ONE  = ERR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               expected;
    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

    // dut_in is the vector register itself, so the applied vector and the
    // one being checked can never disagree.
    always_comb begin
        expected = TRUTH_TABLE[dut_in];
        mismatch = (dut_out !== expected);
        err_next = err_count;
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + ERR_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            dut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= SETTLE;
                        cnt             <= '0;
                        dut_in          <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                    end
                end

                SETTLE: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= dut_in;
                    end
                    // pass reflects this cycle's comparison as well as all earlier ones
                    if (dut_in == '1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state  <= SETTLE;
                        cnt    <= '0;
                        dut_in <= dut_in + VEC_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Scoreboard bench: a default NAND checker with selectable gate faults, plus a
// 3-input saturating-counter configuration with a long settle time.
module tb_gate_exhaustive_checker;

    typedef struct {
        int err;
        int pass;
        int fvalid;
        int fvec;
        int latency;
    } res_t;

    logic clock = 1'b0;
    logic reset_n;
    logic start_a, start_b;
    int   mode_a;

    logic [1:0] a_dut_in;
    logic       a_dut_out, a_busy, a_done, a_pass, a_fvalid;
    logic [7:0] a_err;
    logic [1:0] a_fvec;

    logic [2:0] b_dut_in;
    logic       b_dut_out, b_busy, b_done, b_pass, b_fvalid;
    logic [1:0] b_err;
    logic [2:0] b_fvec;

    int checks = 0;
    int errors = 0;

    int   a_vec_q[$];
    res_t a_res_q[$];
    int   b_vec_q[$];
    res_t b_res_q[$];
    int   a_busy_cycles = 0;
    int   b_busy_cycles = 0;
    logic a_done_d = 1'b0;
    logic b_done_d = 1'b0;

    always #5 clock = ~clock;

    // mode 0: correct NAND, 1: stuck-at-0, 2: stuck-at-1 (wrong only at 11)
    assign a_dut_out = (mode_a == 0) ? ~&a_dut_in : (mode_a == 1) ? 1'b0 : 1'b1;
    assign b_dut_out = 1'b1;

    gate_exhaustive_checker u_a (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start_a),
        .dut_in         (a_dut_in),
        .dut_out        (a_dut_out),
        .busy           (a_busy),
        .done           (a_done),
        .pass           (a_pass),
        .err_count      (a_err),
        .first_err_valid(a_fvalid),
        .first_err_vec  (a_fvec)
    );

    gate_exhaustive_checker #(
        .N_INPUTS     (3),
        .TRUTH_TABLE  (8'h00),
        .SETTLE_CYCLES(3),
        .ERR_W        (2)
    ) u_b (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start_b),
        .dut_in         (b_dut_in),
        .dut_out        (b_dut_out),
        .busy           (b_busy),
        .done           (b_done),
        .pass           (b_pass),
        .err_count      (b_err),
        .first_err_valid(b_fvalid),
        .first_err_vec  (b_fvec)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int gate_model(input int mode, input int v, input int n);
        if (mode == 0) return (v != (1 << n) - 1) ? 1 : 0;
        if (mode == 1) return 0;
        return 1;
    endfunction

    function automatic res_t model(input int n, input int tt, input int errw,
                                   input int mode, input int settle);
        res_t r;
        r.err = 0; r.fvalid = 0; r.fvec = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gate_model(mode, v, n) != ((tt >> v) & 1)) begin
                if (r.err < (1 << errw) - 1) r.err++;
                if (r.fvalid == 0) begin
                    r.fvalid = 1;
                    r.fvec   = v;
                end
            end
        end
        r.pass    = (r.err == 0) ? 1 : 0;
        r.latency = (1 << n) * (settle + 1);
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            if (a_busy) begin
                a_busy_cycles++;
                if (a_vec_q.size() == 0) check("a_vec_underflow", 1, 0);
                else check("a_dut_in", a_dut_in, a_vec_q.pop_front());
                check("a_pass_while_busy", a_pass, 0);
                check("a_done_while_busy", a_done, 0);
            end
            if (a_done && !a_done_d) begin
                if (a_res_q.size() == 0) check("a_res_underflow", 1, 0);
                else begin
                    res_t r;
                    r = a_res_q.pop_front();
                    check("a_err_count", a_err, r.err);
                    check("a_pass", a_pass, r.pass);
                    check("a_first_err_valid", a_fvalid, r.fvalid);
                    check("a_first_err_vec", a_fvec, r.fvec);
                    check("a_latency", a_busy_cycles, r.latency);
                    check("a_busy_at_done", a_busy, 0);
                end
                a_busy_cycles = 0;
            end
            a_done_d = a_done;

            if (b_busy) begin
                b_busy_cycles++;
                if (b_vec_q.size() == 0) check("b_vec_underflow", 1, 0);
                else check("b_dut_in", b_dut_in, b_vec_q.pop_front());
            end
            if (b_done && !b_done_d) begin
                if (b_res_q.size() == 0) check("b_res_underflow", 1, 0);
                else begin
                    res_t r;
                    r = b_res_q.pop_front();
                    check("b_err_count", b_err, r.err);
                    check("b_pass", b_pass, r.pass);
                    check("b_first_err_valid", b_fvalid, r.fvalid);
                    check("b_first_err_vec", b_fvec, r.fvec);
                    check("b_latency", b_busy_cycles, r.latency);
                end
                b_busy_cycles = 0;
            end
            b_done_d = b_done;
        end
    end

    task automatic run_a(input int mode);
        @(posedge clock); #1;
        mode_a = mode;
        for (int v = 0; v < 4; v++) begin
            a_vec_q.push_back(v);
            a_vec_q.push_back(v);
        end
        a_res_q.push_back(model(2, 4'b0111, 8, mode, 1));
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_a(input int max_cycles);
        int n = 0;
        while (a_res_q.size() != 0 && n < max_cycles) begin
            @(posedge clock);
            n++;
        end
        check("a_timeout", a_res_q.size(), 0);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_dut_in"}, a_dut_in, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_pass"}, a_pass, 0);
        check({tag, "_err"}, a_err, 0);
        check({tag, "_fvalid"}, a_fvalid, 0);
        check({tag, "_fvec"}, a_fvec, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        repeat (3) @(posedge clock);
        #1;
        check_a_zero("rst_a");
        check("rst_b_busy", b_busy, 0);
        check("rst_b_err", b_err, 0);
        check("rst_b_dut_in", b_dut_in, 0);
        reset_n = 1'b1;

        // correct NAND, stuck-at-0, stuck-at-1 then a clean rerun from DONE
        run_a(0); wait_a(40);
        run_a(1); wait_a(40);
        run_a(2); wait_a(40);
        run_a(0); wait_a(40);

        // asynchronous abort three cycles into a run
        run_a(0);
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check_a_zero("abort_a");
        a_vec_q.delete();
        a_res_q.delete();
        a_busy_cycles = 0;
        @(posedge clock); #1 reset_n = 1'b1;
        run_a(0); wait_a(40);

        // a second start mid-run must not disturb the sequence or latency
        run_a(0);
        repeat (3) @(posedge clock);
        #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
        wait_a(40);

        // 3-input, long settle, saturating 2-bit counter
        @(posedge clock); #1;
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < 4; k++) b_vec_q.push_back(v);
        b_res_q.push_back(model(3, 8'h00, 2, 2, 3));
        start_b = 1'b1;
        @(posedge clock); #1 start_b = 1'b0;
        begin
            int n = 0;
            while (b_res_q.size() != 0 && n < 100) begin
                @(posedge clock);
                n++;
            end
            check("b_timeout", b_res_q.size(), 0);
        end

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
